// File: rtl/mnist_infer_ctrl.sv
`timescale 1ns/1ps
// Inference sequencer: starts the image loader, counts pixels, waits for the
// core's score vector, runs a sequential argmax and hands the result to the UART.
module mnist_infer_ctrl #(
    parameter int N_PIXELS    = 784,
    parameter int N_CLASS     = 10,
    parameter int SCORE_W     = 8,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_req,
    output logic                       img_start,
    input  logic                       pix_vld,
    input  logic                       res_vld,
    input  logic [N_CLASS*SCORE_W-1:0] res_din,
    output logic                       tx_vld,
    input  logic                       tx_rdy,
    output logic [3:0]                 tx_class,
    output logic [SCORE_W-1:0]         tx_score,
    output logic                       busy,
    output logic                       done,
    output logic                       err_timeout,
    output logic                       err_pixcnt
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_RES,
        ARGMAX,
        REPORT
    } state_e;

    state_e                     state_q, state_d;
    logic [9:0]                 pix_q, pix_d, pix_inc;
    logic [WD_W-1:0]            wd_q, wd_d;
    logic [3:0]                 idx_q, idx_d;
    logic [3:0]                 best_idx_q, best_idx_d;
    logic signed [SCORE_W-1:0]  best_sc_q, best_sc_d;
    logic signed [SCORE_W-1:0]  sc_q [N_CLASS];
    logic signed [SCORE_W-1:0]  sc_d [N_CLASS];
    logic                       img_start_q, img_start_d;
    logic                       done_q, done_d;
    logic                       errt_q, errt_d;
    logic                       errp_q, errp_d;

    assign pix_inc = (pix_q == 10'd1023) ? pix_q : pix_q + 10'd1;

    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        wd_d        = wd_q;
        idx_d       = idx_q;
        best_idx_d  = best_idx_q;
        best_sc_d   = best_sc_q;
        sc_d        = sc_q;
        img_start_d = 1'b0;
        done_d      = 1'b0;
        errt_d      = errt_q;
        errp_d      = errp_q;
        unique case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d     = LOAD;
                    img_start_d = 1'b1;
                    errt_d      = 1'b0;
                    errp_d      = 1'b0;
                    pix_d       = '0;
                    wd_d        = '0;
                end
            end
            LOAD, WAIT_RES: begin
                wd_d = wd_q + WD_W'(1);
                if (pix_vld) begin
                    pix_d = pix_inc;
                    if (state_q == WAIT_RES) errp_d = 1'b1;
                end
                // A result always beats a simultaneous watchdog expiry.
                if (res_vld) begin
                    for (int i = 0; i < N_CLASS; i++)
                        sc_d[i] = res_din[SCORE_W*i +: SCORE_W];
                    best_idx_d = '0;
                    best_sc_d  = res_din[SCORE_W-1:0];
                    idx_d      = 4'd1;
                    state_d    = ARGMAX;
                    if (state_q == LOAD) errp_d = 1'b1;
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    errt_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (state_q == LOAD && pix_vld &&
                             pix_inc == 10'(N_PIXELS)) begin
                    state_d = WAIT_RES;
                end
            end
            ARGMAX: begin
                // Strictly greater keeps the lowest index on ties.
                if (sc_q[idx_q] > best_sc_q) begin
                    best_idx_d = idx_q;
                    best_sc_d  = sc_q[idx_q];
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'(N_CLASS - 1)) state_d = REPORT;
            end
            REPORT: begin
                if (tx_rdy) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pix_q       <= '0;
            wd_q        <= '0;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_sc_q   <= '0;
            sc_q        <= '{default: '0};
            img_start_q <= 1'b0;
            done_q      <= 1'b0;
            errt_q      <= 1'b0;
            errp_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            wd_q        <= wd_d;
            idx_q       <= idx_d;
            best_idx_q  <= best_idx_d;
            best_sc_q   <= best_sc_d;
            sc_q        <= sc_d;
            img_start_q <= img_start_d;
            done_q      <= done_d;
            errt_q      <= errt_d;
            errp_q      <= errp_d;
        end
    end

    assign img_start   = img_start_q;
    assign done        = done_q;
    assign err_timeout = errt_q;
    assign err_pixcnt  = errp_q;
    assign busy        = (state_q != IDLE);
    assign tx_vld      = (state_q == REPORT);
    assign tx_class    = best_idx_q;
    assign tx_score    = best_sc_q;

endmodule
